// File: rtl/gen_ppdrain.sv
// In-order drain engine for an indexed entry buffer: walks entries 0..DP-1 with
// wrap, captures each valid entry into a registered valid/ready output stage.
module gen_ppdrain #(
  parameter int DW = 100,
  parameter int DP = 8,
  localparam int PW = $clog2(DP)
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [DW*DP-1:0] info_i,
  input  logic [DP-1:0]    valid_i,
  input  logic             flush,
  output logic [DW-1:0]    data_o,
  output logic             data_valid_o,
  input  logic             data_ready_i,
  output logic             last_o,
  output logic             pop_o,
  output logic [PW-1:0]    index_o,
  output logic [PW-1:0]    rd_ptr_o,
  output logic             empty_o
);

  // Handshake: data_o is transferred on any rising edge where data_valid_o and
  // data_ready_i are both high; data_o/last_o hold stable while valid && !ready.

  typedef enum logic {ST_EMPTY = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t        state;
  logic [PW-1:0] rd_ptr;
  logic [DW-1:0] entries [DP];
  logic          slot_free;
  logic          load;
  logic          ptr_at_end;

  for (genvar k = 0; k < DP; k++) begin : g_unpack
    assign entries[k] = info_i[DW*k +: DW];
  end

  assign ptr_at_end = (rd_ptr == PW'(DP - 1));
  assign slot_free  = (state == ST_EMPTY) | data_ready_i;
  // Gated by RSTn so no pop is issued to the buffer while reset is asserted.
  assign load       = RSTn & slot_free & valid_i[rd_ptr] & ~flush;

  assign data_valid_o = (state == ST_HOLD);
  assign pop_o        = load;
  assign index_o      = load ? rd_ptr : '0;
  assign rd_ptr_o     = rd_ptr;
  assign empty_o      = (state == ST_EMPTY) & ~valid_i[rd_ptr];

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state  <= ST_EMPTY;
      rd_ptr <= '0;
      data_o <= '0;
      last_o <= 1'b0;
    end else if (flush) begin
      // data_o deliberately left as-is; only the valid flag is dropped.
      state  <= ST_EMPTY;
      rd_ptr <= '0;
      last_o <= 1'b0;
    end else if (load) begin
      state  <= ST_HOLD;
      data_o <= entries[rd_ptr];
      last_o <= ptr_at_end;
      rd_ptr <= ptr_at_end ? '0 : rd_ptr + PW'(1);
    end else if (state == ST_HOLD && data_ready_i) begin
      state  <= ST_EMPTY;
    end
  end

endmodule

// File: tb/tb_gen_ppdrain.sv
// Directed bench for gen_ppdrain (DW=8, DP=4): one task per scenario with
// hand-computed expectations, inputs changed 1ns after each rising edge.
module tb_gen_ppdrain;

  localparam int DW = 8;
  localparam int DP = 4;

  logic            clk;
  logic            rstn;
  logic [DW*DP-1:0] info;
  logic [DP-1:0]   valid;
  logic            flush;
  logic [DW-1:0]   data;
  logic            data_valid;
  logic            data_ready;
  logic            last;
  logic            pop;
  logic [1:0]      index;
  logic [1:0]      rd_ptr;
  logic            empty;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  gen_ppdrain #(.DW(DW), .DP(DP)) dut (
    .CLK(clk), .RSTn(rstn), .info_i(info), .valid_i(valid), .flush(flush),
    .data_o(data), .data_valid_o(data_valid), .data_ready_i(data_ready),
    .last_o(last), .pop_o(pop), .index_o(index), .rd_ptr_o(rd_ptr),
    .empty_o(empty)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; info = '0; valid = 4'b0001; flush = 1'b0; data_ready = 1'b0;
    tick(); tick();
    #1;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rst_dv: got %b exp 0", data_valid); end
    checks++; if (rd_ptr !== 2'd0) begin errors++; $display("FAIL rst_ptr: got %0d exp 0", rd_ptr); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h exp 00", data); end
    checks++; if (last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b exp 0", last); end
    checks++; if (pop !== 1'b0 || index !== 2'd0) begin errors++; $display("FAIL rst_pop: got pop=%b idx=%0d exp 0/0", pop, index); end
    valid = 4'b0000;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b exp 1", empty); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    info = '0; info[7:0] = 8'hA5; valid = 4'b0001; data_ready = 1'b1;
    #1;
    checks++; if (pop !== 1'b1 || index !== 2'd0) begin errors++; $display("FAIL single_pop: got pop=%b idx=%0d exp 1/0", pop, index); end
    tick();
    valid = 4'b0000;
    #1;
    checks++; if (data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h exp a5", data); end
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL single_dv: got %b exp 1", data_valid); end
    checks++; if (rd_ptr !== 2'd1) begin errors++; $display("FAIL single_ptr: got %0d exp 1", rd_ptr); end
    checks++; if (last !== 1'b0) begin errors++; $display("FAIL single_last: got %b exp 0", last); end
    tick();
    checks++; if (data_valid !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL single_drain: got dv=%b empty=%b exp 0/1", data_valid, empty); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_d;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    info = {8'h44, 8'h33, 8'h22, 8'h11};
    valid = 4'b1111; data_ready = 1'b1;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (pop !== 1'b1 || index !== 2'(k)) begin errors++; $display("FAIL b2b_pop%0d: got pop=%b idx=%0d exp 1/%0d", k, pop, index, k); end
      tick();
      valid[k] = 1'b0;
      #1;
      exp_d = exp_q.pop_front();
      checks++; if (data !== exp_d || data_valid !== 1'b1) begin errors++; $display("FAIL b2b_data%0d: got %h dv=%b exp %h dv=1", k, data, data_valid, exp_d); end
      checks++; if (last !== (k == 3)) begin errors++; $display("FAIL b2b_last%0d: got %b exp %b", k, last, (k == 3)); end
      checks++; if (rd_ptr !== 2'((k + 1) % 4)) begin errors++; $display("FAIL b2b_ptr%0d: got %0d exp %0d", k, rd_ptr, (k + 1) % 4); end
    end
    checks++; if (pop !== 1'b0) begin errors++; $display("FAIL b2b_idle_pop: got %b exp 0", pop); end
    tick();
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b exp 0", data_valid); end
  endtask

  task automatic test_backpressure();
    info = {8'h00, 8'h00, 8'h66, 8'h55};
    valid = 4'b0011; data_ready = 1'b1;
    tick();
    valid = 4'b0010; data_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (pop !== 1'b0) begin errors++; $display("FAIL bp_pop%0d: got %b exp 0", c, pop); end
      checks++; if (data !== 8'h55 || data_valid !== 1'b1) begin errors++; $display("FAIL bp_hold%0d: got %h dv=%b exp 55 dv=1", c, data, data_valid); end
      checks++; if (rd_ptr !== 2'd1) begin errors++; $display("FAIL bp_ptr%0d: got %0d exp 1", c, rd_ptr); end
      tick();
    end
    data_ready = 1'b1;
    #1;
    checks++; if (pop !== 1'b1 || index !== 2'd1) begin errors++; $display("FAIL bp_release: got pop=%b idx=%0d exp 1/1", pop, index); end
    tick();
    valid = 4'b0000;
    #1;
    checks++; if (data !== 8'h66 || rd_ptr !== 2'd2) begin errors++; $display("FAIL bp_next: got %h ptr=%0d exp 66 ptr=2", data, rd_ptr); end
    tick();
  endtask

  task automatic test_no_skip();
    info = {8'h88, 8'h77, 8'h00, 8'h00};
    valid = 4'b1001; data_ready = 1'b1;
    #1;
    checks++; if (pop !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL skip_stall: got pop=%b empty=%b exp 0/1", pop, empty); end
    tick();
    checks++; if (rd_ptr !== 2'd2 || data_valid !== 1'b0) begin errors++; $display("FAIL skip_ptr: got ptr=%0d dv=%b exp 2/0", rd_ptr, data_valid); end
    valid = 4'b1101;
    #1;
    checks++; if (pop !== 1'b1 || index !== 2'd2) begin errors++; $display("FAIL skip_pop2: got pop=%b idx=%0d exp 1/2", pop, index); end
    tick();
    valid = 4'b1001;
    #1;
    checks++; if (data !== 8'h77) begin errors++; $display("FAIL skip_data2: got %h exp 77", data); end
    checks++; if (pop !== 1'b1 || index !== 2'd3) begin errors++; $display("FAIL skip_pop3: got pop=%b idx=%0d exp 1/3", pop, index); end
    tick();
    valid = 4'b0000;
    #1;
    checks++; if (data !== 8'h88 || last !== 1'b1 || rd_ptr !== 2'd0) begin errors++; $display("FAIL skip_data3: got %h last=%b ptr=%0d exp 88 last=1 ptr=0", data, last, rd_ptr); end
    tick();
  endtask

  task automatic test_flush();
    info = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    valid = 4'b0111; data_ready = 1'b1;
    tick(); valid = 4'b0110;
    tick(); valid = 4'b0100;
    tick(); valid = 4'b1000;
    #1;
    checks++; if (data_valid !== 1'b1 || rd_ptr !== 2'd3 || data !== 8'hC3) begin errors++; $display("FAIL flush_setup: got dv=%b ptr=%0d data=%h exp 1/3/c3", data_valid, rd_ptr, data); end
    flush = 1'b1;
    #1;
    checks++; if (pop !== 1'b0) begin errors++; $display("FAIL flush_pop: got %b exp 0", pop); end
    tick();
    flush = 1'b0;
    #1;
    checks++; if (data_valid !== 1'b0 || rd_ptr !== 2'd0 || last !== 1'b0) begin errors++; $display("FAIL flush_state: got dv=%b ptr=%0d last=%b exp 0/0/0", data_valid, rd_ptr, last); end
    checks++; if (data !== 8'hC3) begin errors++; $display("FAIL flush_data_kept: got %h exp c3", data); end
    valid = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid();
    info = {8'h00, 8'h00, 8'h5B, 8'h5A};
    valid = 4'b0001; data_ready = 1'b1;
    tick();
    valid = 4'b0010; data_ready = 1'b0;
    #1;
    checks++; if (data_valid !== 1'b1 || rd_ptr !== 2'd1) begin errors++; $display("FAIL rmid_setup: got dv=%b ptr=%0d exp 1/1", data_valid, rd_ptr); end
    rstn = 1'b0; data_ready = 1'b1;
    #1;
    checks++; if (pop !== 1'b0) begin errors++; $display("FAIL rmid_pop_in_reset: got %b exp 0", pop); end
    tick();
    rstn = 1'b1; valid = 4'b0000;
    #1;
    checks++; if (data_valid !== 1'b0 || rd_ptr !== 2'd0 || pop !== 1'b0) begin errors++; $display("FAIL rmid_state: got dv=%b ptr=%0d pop=%b exp 0/0/0", data_valid, rd_ptr, pop); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL rmid_data: got %h exp 00", data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_no_skip();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gen_ppdrain.md
Name: gen_ppdrain

Overview:
- In-order read/drain engine for a DP-entry indexed entry buffer. The buffer exposes a flat info bus and a per-entry valid vector.
- Walks entries in strict ascending index order with wrap-around, DP-1 -> 0.
- Captures each entry into a registered output stage with a valid/ready handshake.
- For each captured entry, returns a one-cycle pop pulse and the entry index so the buffer can free it.
- Sits between an indexed entry buffer (writer side) and a downstream consumer such as a commit or writeback stage.

Parameters:
- DW, 100, width of one entry in bits.
- DP, 8, number of entries; any value >= 2; pointer width is $clog2(DP).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RSTn  input  1  reset, synchronous, active-low.
- info_i  input  DW*DP  flat entry bus; entry k occupies bits [DW*k +: DW].
- valid_i  input  DP  per-entry valid from the buffer.
- flush  input  1  discard the output stage and restart at index 0.
- data_o  output  DW  registered entry data.
- data_valid_o  output  1  data_o holds an undelivered entry.
- data_ready_i  input  1  consumer accepts data_o.
- last_o  output  1  registered; the entry in data_o came from index DP-1.
- pop_o  output  1  one-cycle pulse: the entry at index_o was captured this cycle.
- index_o  output  $clog2(DP)  index being released; meaningful only while pop_o = 1.
- rd_ptr_o  output  $clog2(DP)  current read pointer, for debug and status.
- empty_o  output  1  combinational: data_valid_o = 0 and valid_i[rd_ptr] = 0.

Behaviour:
- Reset (RSTn = 0 at a clock edge):
  - rd_ptr = 0, data_valid_o = 0, data_o = 0, last_o = 0.
  - pop_o = 0 and index_o = 0 from that edge on.
  - Reset mid-transfer drops the held entry with no pop.
- Output slot free: slot_free = ~data_valid_o | data_ready_i.
- load = slot_free & valid_i[rd_ptr] & ~flush.
- On load, at the clock edge:
  - data_o <= info_i[DW*rd_ptr +: DW].
  - last_o <= (rd_ptr == DP-1).
  - data_valid_o <= 1.
  - rd_ptr <= (rd_ptr == DP-1) ? 0 : rd_ptr + 1. Explicit compare, so a non-power-of-2 DP wraps correctly.
- pop_o and index_o:
  - Combinational in the load cycle: pop_o = load, index_o = rd_ptr (the value before increment).
  - The buffer frees the entry on the same edge the data is captured.
  - Latency from valid_i[k] rising to data_valid_o is 1 cycle when the slot is free.
- Accept without reload: if data_ready_i & data_valid_o and load = 0, then data_valid_o <= 0.
- Back-to-back: with data_ready_i held at 1 and valid entries present, one entry is delivered and one popped per cycle.
- In-order, no skip: if valid_i[rd_ptr] = 0, the engine stalls at rd_ptr even when other entries are valid.
- Backpressure: while data_valid_o = 1 and data_ready_i = 0:
  - data_o and last_o hold stable.
  - pop_o = 0 and rd_ptr does not move.
- Flush (has priority over load and accept):
  - Next edge: data_valid_o <= 0, rd_ptr <= 0, last_o <= 0.
  - pop_o = 0 in the flush cycle.
  - data_o is not cleared.
- Ordering guarantee: valid_i may drop for an already-captured entry without effect. The captured data is owned by the output stage.
- No internal FSM beyond the states {EMPTY: data_valid_o = 0, HOLD: data_valid_o = 1}. Transitions follow the load, accept and flush rules above.

Test Plan (DW=8, DP=4):
- Reset, then valid_i = 4'b0001, info entry0 = 8'hA5, data_ready_i = 1:
  - Cycle 0: pop_o = 1, index_o = 0.
  - Next cycle: data_o = A5, data_valid_o = 1, rd_ptr_o = 1, last_o = 0.
- Entries 0..3 = 11,22,33,44, all valid, ready held at 1, buffer clears each valid on pop:
  - data_o = 11,22,33,44 on consecutive cycles.
  - last_o = 1 only with 44.
  - rd_ptr_o wraps to 0.
- Hold data_ready_i = 0 for 3 cycles with entry1 pending:
  - data_o is stable, pop_o = 0, rd_ptr_o = 1.
  - Raise ready: entry1 is popped in that cycle and delivered next.
- rd_ptr = 2, valid_i = 4'b1001 (entry2 not valid):
  - No pop and empty_o = 1.
  - Set valid_i[2]: index_o = 2 pops before index 3.
- Flush while data_valid_o = 1, rd_ptr = 3, and load conditions true:
  - pop_o = 0.
  - Next cycle: data_valid_o = 0, rd_ptr_o = 0.
- Drive RSTn = 0 for one edge mid-stream with data_valid_o = 1:
  - Next cycle: data_valid_o = 0, rd_ptr_o = 0, pop_o = 0.
